ssd_to_hex_reader: RTL and testbench

SSD_TO_HEX_READER -- requirements
Module: ssd_to_hex_reader

---
 rtl/ssd_to_hex_reader.sv | 156 +++++++++++++++
 tb/tb_ssd_to_hex_reader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ssd_to_hex_reader.sv
// ssd_to_hex_reader
// Reads an active-low seven-segment pattern (bit0=a .. bit6=g) and decodes
// it into a hex digit. A pattern must be seen on STABLE consecutive enabled
// samples before it is acted on. Each qualification of the pattern reports
// one of three results:
//   - Valid/Q : the pattern is a legal hex glyph, and Q holds its digit
//   - Blank   : the pattern is 7'h7F (all segments off)
//   - Err     : the pattern is anything else
// Optional feature: define SSD_TO_HEX_READER_ERRCNT_EN to build the 8-bit
// saturating counter of qualified illegal patterns on ErrCnt. Without the
// macro, ErrCnt is tied to zero and no counter register exists.
module ssd_to_hex_reader #(
  parameter int STABLE = 3
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       En,
  input  logic [6:0] SSD,
  output logic [3:0] Q,
  output logic       Valid,
  output logic       Err,
  output logic       Blank,
  output logic [7:0] ErrCnt
);

  // Qualification threshold, resized to the width of the sample counter.
  localparam logic [3:0] STABLE_C  = 4'(STABLE);

  // Pattern with all segments off.
  localparam logic [6:0] BLANK_PAT = 7'h7F;

  // The two states are not stored separately; they are read from cnt.
  localparam logic       ST_SETTLE = 1'b0;
  localparam logic       ST_LOCKED = 1'b1;

  // Returns {legal, digit} for an active-low segment pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // Saturating 8-bit increment for the error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [6:0] prev;
  logic [3:0] cnt;
  logic       state;
  logic       change;
  logic       same_settle;
  logic [3:0] cnt_nxt;
  logic       qualify;
  logic [4:0] dec;
  logic       is_legal;
  logic       is_blank;
  logic       is_illegal;

  // Next-state decision: a new pattern, or another matching sample while
  // still settling. A LOCKED pattern never qualifies again, so each
  // episode is reported once. With STABLE=1, a new pattern qualifies on
  // the same edge that loads it.
  always_comb begin
    state       = (cnt == STABLE_C) ? ST_LOCKED : ST_SETTLE;
    change      = En && (SSD != prev);
    same_settle = En && (SSD == prev) && (state == ST_SETTLE);
    cnt_nxt     = cnt;
    if (change) begin
      cnt_nxt = 4'd1;
    end else if (same_settle) begin
      cnt_nxt = cnt + 4'd1;
    end
    qualify     = (change || same_settle) && (cnt_nxt == STABLE_C);
    dec         = seg_decode(SSD);
    is_legal    = dec[4];
    is_blank    = (SSD == BLANK_PAT);
    is_illegal  = !is_legal && !is_blank;
  end

  // Sample history and decoded outputs. Clr wins over everything else.
  // A new pattern clears the flags, and Q keeps its last value. On the
  // qualifying edge, the flags follow the class of the pattern. Both
  // assignments are in one block, so with STABLE=1 the qualification
  // overrides the clearing.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      prev  <= BLANK_PAT;
      cnt   <= STABLE_C;
      Q     <= 4'h0;
      Valid <= 1'b0;
      Err   <= 1'b0;
      Blank <= 1'b1;
    end else begin
      if (change) begin
        prev  <= SSD;
        Valid <= 1'b0;
        Err   <= 1'b0;
        Blank <= 1'b0;
      end
      cnt <= cnt_nxt;
      if (qualify) begin
        if (is_legal) begin
          Q     <= dec[3:0];
          Valid <= 1'b1;
          Err   <= 1'b0;
          Blank <= 1'b0;
        end else if (is_blank) begin
          Valid <= 1'b0;
          Err   <= 1'b0;
          Blank <= 1'b1;
        end else begin
          Valid <= 1'b0;
          Err   <= 1'b1;
          Blank <= 1'b0;
        end
      end
    end
  end

`ifdef SSD_TO_HEX_READER_ERRCNT_EN
  logic [7:0] err_cnt;

  // Counts qualified illegal episodes, and stops at 255.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      err_cnt <= 8'h00;
    end else if (qualify && is_illegal) begin
      err_cnt <= sat_inc8(err_cnt);
    end
  end

  assign ErrCnt = err_cnt;
`else
  assign ErrCnt = 8'h00;
`endif

endmodule

// File: tb/tb_ssd_to_hex_reader.sv
// Self-checking bench for ssd_to_hex_reader (STABLE=3). A reference model
// tracks the length of the current run of identical enabled samples and
// classifies the pattern from a glyph table, independently of the DUT.
module tb_ssd_to_hex_reader;

  localparam int STABLE = 3;

  logic       Clk = 1'b0;
  logic       Clr = 1'b0;
  logic       En  = 1'b0;
  logic [6:0] SSD = 7'h7F;
  logic [3:0] Q;
  logic       Valid;
  logic       Err;
  logic       Blank;
  logic [7:0] ErrCnt;

  int checks = 0;
  int errors = 0;

  ssd_to_hex_reader #(.STABLE(STABLE)) dut (
    .Clk    (Clk),
    .Clr    (Clr),
    .En     (En),
    .SSD    (SSD),
    .Q      (Q),
    .Valid  (Valid),
    .Err    (Err),
    .Blank  (Blank),
    .ErrCnt (ErrCnt)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] m_last;
  int         m_run;
  logic [3:0] m_q;
  logic       m_valid, m_err, m_blank;
  int         m_errcnt;

  function automatic int glyph_index(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic clr, input logic en, input logic [6:0] ssd);
    int idx;
    if (clr) begin
      m_last = 7'h7F; m_run = STABLE; m_q = 4'h0;
      m_valid = 1'b0; m_err = 1'b0; m_blank = 1'b1; m_errcnt = 0;
    end else if (en) begin
      if (ssd != m_last) begin
        m_last = ssd; m_run = 1;
        m_valid = 1'b0; m_err = 1'b0; m_blank = 1'b0;
      end else begin
        m_run = m_run + 1;
      end
      if (m_run == STABLE) begin
        idx = glyph_index(ssd);
        if (idx >= 0) begin
          m_q = 4'(idx); m_valid = 1'b1; m_err = 1'b0; m_blank = 1'b0;
        end else if (ssd == 7'h7F) begin
          m_valid = 1'b0; m_err = 1'b0; m_blank = 1'b1;
        end else begin
          m_valid = 1'b0; m_err = 1'b1; m_blank = 1'b0;
`ifdef SSD_TO_HEX_READER_ERRCNT_EN
          if (m_errcnt < 255) m_errcnt = m_errcnt + 1;
`endif
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_q"},      {4'h0, Q},       {4'h0, m_q});
    check({tag, "_valid"},  {7'h0, Valid},   {7'h0, m_valid});
    check({tag, "_err"},    {7'h0, Err},     {7'h0, m_err});
    check({tag, "_blank"},  {7'h0, Blank},   {7'h0, m_blank});
    check({tag, "_errcnt"}, ErrCnt,          8'(m_errcnt));
  endtask

  // One clock edge with the given inputs; outputs are checked 1 time unit later.
  task automatic step(input logic clr, input logic en, input logic [6:0] ssd, input string tag);
    Clr = clr; En = en; SSD = ssd;
    @(posedge Clk);
    model_edge(clr, en, ssd);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [6:0] pat;
    int         hold;
    int         r;

    // Reset state
    @(negedge Clk);
    step(1'b1, 1'b0, 7'h7F, "reset");
    check("reset_blank_const", {7'h0, Blank}, 8'h01);
    check("reset_valid_const", {7'h0, Valid}, 8'h00);

    // Latency: "2" qualifies on edge 3, not before
    step(1'b0, 1'b1, 7'h24, "lat_e1");
    step(1'b0, 1'b1, 7'h24, "lat_e2");
    check("lat_e2_valid_const", {7'h0, Valid}, 8'h00);
    step(1'b0, 1'b1, 7'h24, "lat_e3");
    check("lat_e3_valid_const", {7'h0, Valid}, 8'h01);
    check("lat_e3_q_const", {4'h0, Q}, 8'h02);

    // A glitch to "3" breaks the run and never shows up
    step(1'b0, 1'b1, 7'h7F, "glt_pre");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 7'h24, "glt_a");
    step(1'b0, 1'b1, 7'h30, "glt_b");
    check("glt_no3", {4'h0, Q}, 8'h02);
    step(1'b0, 1'b1, 7'h24, "glt_c1");
    step(1'b0, 1'b1, 7'h24, "glt_c2");
    check("glt_c2_valid_const", {7'h0, Valid}, 8'h00);
    step(1'b0, 1'b1, 7'h24, "glt_c3");
    check("glt_c3_valid_const", {7'h0, Valid}, 8'h01);

    // An illegal pattern held for 13 edges is counted once
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 7'h7E, "ill_hold");
    check("ill_err_const", {7'h0, Err}, 8'h01);

    // Cycles with En low neither break the run nor count toward it
    step(1'b1, 1'b0, 7'h7F, "en_rst");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 7'h10, "en_on");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 7'h10, "en_off");
    check("en_off_valid_const", {7'h0, Valid}, 8'h00);
    step(1'b0, 1'b1, 7'h10, "en_last");
    check("en_last_q_const", {4'h0, Q}, 8'h09);

    // Randomized episodes with occasional reset
    for (int ep = 0; ep < 150; ep++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       pat = seg_tab[$urandom_range(0, 15)];
      else if (r == 6) pat = 7'h7F;
      else             pat = 7'($urandom);
      hold = $urandom_range(1, 5);
      for (int k = 0; k < hold; k++)
        step(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), pat, "rand");
    end

    // The error counter saturates
    step(1'b1, 1'b0, 7'h7F, "sat_rst");
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, (n % 2 == 0) ? 7'h7E : 7'h7D, "sat");
    end
`ifdef SSD_TO_HEX_READER_ERRCNT_EN
    check("sat_const", ErrCnt, 8'hFF);
`else
    check("sat_const", ErrCnt, 8'h00);
`endif

    // Clr during settling throws away the partial history
    step(1'b0, 1'b1, 7'h24, "mid_e1");
    step(1'b1, 1'b1, 7'h24, "mid_clr");
    check("mid_clr_blank_const", {7'h0, Blank}, 8'h01);
    check("mid_clr_cnt_const", ErrCnt, 8'h00);
    step(1'b0, 1'b1, 7'h24, "mid_r1");
    step(1'b0, 1'b1, 7'h24, "mid_r2");
    check("mid_r2_valid_const", {7'h0, Valid}, 8'h00);
    step(1'b0, 1'b1, 7'h24, "mid_r3");
    check("mid_r3_valid_const", {7'h0, Valid}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
